// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN front end (synapse accumulator and neuron).
package snn_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} syn_acc_state_t;

    localparam int unsigned DEF_N_SYN     = 8;
    localparam int unsigned DEF_W_WIDTH   = 8;
    localparam int unsigned DEF_OUT_WIDTH = 10;

    // Clamp a signed value into [0, hi].
    function automatic logic [31:0] sat_clamp(input logic signed [31:0] value,
                                              input logic signed [31:0] hi);
        if (value < 0) begin
            return '0;
        end else if (value > hi) begin
            return hi;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/synapse_weight_ram.sv
// Per-synapse weight register file: synchronous write, asynchronous read, synchronous clear.
module synapse_weight_ram #(
    parameter int unsigned N_SYN   = 8,
    parameter int unsigned W_WIDTH = 8,
    parameter int unsigned AW      = $clog2(N_SYN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [W_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [W_WIDTH-1:0] rd_data
);

    logic [W_WIDTH-1:0] mem [N_SYN];

    // Reset takes priority over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_SYN); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/synapse_accumulator.sv
// Serial weighted spike accumulator feeding the LIF neuron.
// Define SYN_SIGNED_WEIGHT_EN for two's-complement (inhibitory) weights with [0, max] clamp.
module synapse_accumulator
    import snn_pkg::*;
#(
    parameter int unsigned N_SYN     = DEF_N_SYN,
    parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(N_SYN)-1:0] wr_addr,
    input  logic [W_WIDTH-1:0]       wr_data,
    input  logic [N_SYN-1:0]         spike_in,
    input  logic                     start,
    output logic                     busy,
    output logic [OUT_WIDTH-1:0]     synapse_data,
    output logic                     data_valid
);

    localparam int unsigned AW      = $clog2(N_SYN);
    localparam int unsigned ACC_W   = W_WIDTH + AW + 1;
    localparam int unsigned OUT_MAX = (1 << OUT_WIDTH) - 1;

    syn_acc_state_t state, next_state;

    logic [N_SYN-1:0]     spike_reg, spike_d;
    logic [AW-1:0]        idx, idx_d;
    logic [ACC_W-1:0]     acc, acc_d;
    logic [OUT_WIDTH-1:0] data_d;
    logic                 valid_d;
    logic                 busy_d;

    logic [W_WIDTH-1:0]   rd_data;
    logic [ACC_W-1:0]     w_ext;
    logic [31:0]          acc_clamped;

    synapse_weight_ram #(
        .N_SYN   (N_SYN),
        .W_WIDTH (W_WIDTH),
        .AW      (AW)
    ) u_weight_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

`ifdef SYN_SIGNED_WEIGHT_EN
    assign w_ext       = ACC_W'(signed'(rd_data));
    assign acc_clamped = sat_clamp(32'(signed'(acc)), 32'(OUT_MAX));
`else
    assign w_ext       = ACC_W'(rd_data);
    assign acc_clamped = sat_clamp(32'(acc), 32'(OUT_MAX));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACCUM;
            ACCUM:   if (idx == AW'(N_SYN - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath next values; the read of weight[idx] is combinational, so a
    // same-cycle write to that slot is summed with its old value.
    always_comb begin
        spike_d = spike_reg;
        idx_d   = idx;
        acc_d   = acc;
        data_d  = synapse_data;
        valid_d = 1'b0;
        busy_d  = (next_state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    spike_d = spike_in;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            ACCUM: begin
                if (spike_reg[idx]) acc_d = acc + w_ext;
                if (idx != AW'(N_SYN - 1)) idx_d = idx + AW'(1);
            end
            DONE: begin
                data_d  = OUT_WIDTH'(acc_clamped);
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_reg    <= '0;
            idx          <= '0;
            acc          <= '0;
            synapse_data <= '0;
            data_valid   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            spike_reg    <= spike_d;
            idx          <= idx_d;
            acc          <= acc_d;
            synapse_data <= data_d;
            data_valid   <= valid_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Self-checking bench for synapse_accumulator against a sum-of-active-weights model.
// Honours SYN_SIGNED_WEIGHT_EN the same way as the design.
module tb_synapse_accumulator;

    localparam int N   = 8;
    localparam int MAX = 1023;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] spike_in;
    logic       start;
    logic       busy;
    logic [9:0] synapse_data;
    logic       data_valid;

    int checks = 0;
    int errors = 0;
    logic [7:0] wm [N];

    synapse_accumulator #(
        .N_SYN     (8),
        .W_WIDTH   (8),
        .OUT_WIDTH (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .spike_in     (spike_in),
        .start        (start),
        .busy         (busy),
        .synapse_data (synapse_data),
        .data_valid   (data_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int wval(input logic [7:0] w);
`ifdef SYN_SIGNED_WEIGHT_EN
        return int'($signed(w));
`else
        return int'(w);
`endif
    endfunction

    // Sum of weights of fired synapses, clamped to [0, MAX].
    function automatic int model_sum(input logic [7:0] sp);
        int s = 0;
        for (int i = 0; i < N; i++) if (sp[i]) s += wval(wm[i]);
        if (s < 0) return 0;
        if (s > MAX) return MAX;
        return s;
    endfunction

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        wm[a]   = d;
    endtask

    // One accumulation; optionally a weight write in ACCUM cycle wr_cycle and
    // spurious start pulses with a toggled spike vector mid-run.
    task automatic run_check(input string tag, input logic [7:0] sp, input bit disturb,
                             input int wr_cycle, input int waddr, input logic [7:0] wdata);
        int  expv;
        int  n;
        int  extra;
        bit  seen;
        expv     = model_sum(sp);
        spike_in = sp;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_accum"}, 32'(busy), 32'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (n == wr_cycle) begin
                wr_en   = 1'b1;
                wr_addr = 3'(waddr);
                wr_data = wdata;
            end
            if (disturb && (n == 3 || n == 5)) begin
                start    = 1'b1;
                spike_in = ~sp;
            end
            tick();
            n++;
            wr_en = 1'b0;
            start = 1'b0;
            seen  = data_valid;
        end
        if (wr_cycle >= 0) wm[waddr] = wdata;
        chk({tag, "_latency"}, 32'(n), 32'(N + 1));
        chk({tag, "_data"}, 32'(synapse_data), 32'(expv));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        extra = 0;
        repeat (N + 4) begin
            tick();
            if (data_valid) extra++;
            if (synapse_data != 10'(expv)) extra++;
        end
        chk({tag, "_single_pulse_hold"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int cnt;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        spike_in = '0;
        start    = 1'b0;
        for (int i = 0; i < N; i++) wm[i] = '0;
        tick();
        tick();
        chk("reset_data", 32'(synapse_data), 32'd0);
        chk("reset_valid", 32'(data_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Weights i+1, synapses 0 and 2 fire.
        for (int i = 0; i < N; i++) wr(i, 8'(i + 1));
        run_check("t1", 8'b0000_0101, 1'b0, -1, 0, 8'd0);
        chk("t1_const", 32'(synapse_data), 32'd4);

        // Saturation and an empty spike vector.
        for (int i = 0; i < N; i++) wr(i, 8'd255);
        run_check("t2_all", 8'hFF, 1'b0, -1, 0, 8'd0);
        run_check("t2_none", 8'h00, 1'b0, -1, 0, 8'd0);
        chk("t2_none_const", 32'(synapse_data), 32'd0);

        // Starts during ACCUM ignored, spike_in changes ignored.
        for (int i = 0; i < N; i++) wr(i, 8'(i + 1));
        run_check("t3", 8'b1010_0110, 1'b1, -1, 0, 8'd0);

        // Write to the slot being summed: old weight now, new one next run.
        run_check("t4_old", 8'b0000_0100, 1'b0, 2, 2, 8'd50);
        chk("t4_old_const", 32'(synapse_data), 32'd3);
        run_check("t4_new", 8'b0000_0100, 1'b0, -1, 0, 8'd0);
        chk("t4_new_const", 32'(synapse_data), 32'd50);

        // Reset mid-ACCUM with a coincident write; reset wins.
        spike_in = 8'hFF;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 8'd77;
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < N; i++) wm[i] = '0;
        chk("t5_data", 32'(synapse_data), 32'd0);
        chk("t5_valid", 32'(data_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        cnt = 0;
        repeat (2 * N) begin
            tick();
            if (data_valid) cnt++;
        end
        chk("t5_no_valid", 32'(cnt), 32'd0);
        run_check("t5_zero_w", 8'hFF, 1'b0, -1, 0, 8'd0);
        for (int i = 0; i < N; i++) wr(i, 8'(i + 1));
        run_check("t5_rerun", 8'hFF, 1'b0, -1, 0, 8'd0);
        chk("t5_rerun_const", 32'(synapse_data), 32'd36);

        // Randomised weights and spike vectors.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) wr(i, 8'($urandom));
            run_check("rand", 8'($urandom), 1'b0, -1, 0, 8'd0);
        end

`ifdef SYN_SIGNED_WEIGHT_EN
        // Inhibitory weight drives the sum negative, clamped to zero.
        wr(0, 8'(-20));
        wr(1, 8'd5);
        run_check("t6_neg", 8'b0000_0011, 1'b0, -1, 0, 8'd0);
        chk("t6_neg_const", 32'(synapse_data), 32'd0);
        wr(0, 8'd20);
        run_check("t6_pos", 8'b0000_0011, 1'b0, -1, 0, 8'd0);
        chk("t6_pos_const", 32'(synapse_data), 32'd25);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
